ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single on-chip RAM port between the Z80 (qualified by the address decoder's RAM chip-select) and a DMA requester, for example the sector-transfer engine. It serialises accesses and sequences each one through issue and read-latency phases. It stretches Z80 memory cycles via WAIT until the CPU's access has completed, and returns DMA read data with a strobe. It sits between the address decoder/CPU bus and the RAM primitive.

## Interface
Parameters:
- ADDR_W, 16, RAM/bus address width
- DATA_W, 8, data width
- RAM_LAT, 1, RAM read latency in cycles from enable to valid ram_data_i; legal range 1–7

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- cpu_cs_i  in  1  RAM select from address decoder (MREQ-qualified)
- cpu_rd_n_i  in  1  Z80 RD_n
- cpu_wr_n_i  in  1  Z80 WR_n
- cpu_addr_i  in  ADDR_W  Z80 address
- cpu_data_i  in  DATA_W  Z80 write data
- cpu_data_o  out  DATA_W  registered CPU read data
- cpu_wait_n_o  out  1  Z80 WAIT_n, low stretches cycle
- dma_req_i  in  1  DMA request, level, held until ack
- dma_we_i  in  1  1 = write
- dma_addr_i  in  ADDR_W  DMA address, stable while req
- dma_data_i  in  DATA_W  DMA write data, stable while req
- dma_ack_o  out  1  one-cycle pulse: request accepted
- dma_data_o  out  DATA_W  DMA read data
- dma_valid_o  out  1  one-cycle pulse: dma_data_o valid
- ram_en_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_data_o  out  DATA_W  RAM write data
- ram_data_i  in  DATA_W  RAM read data

## Operation
- CPU pending: cpu_cs_i & (~cpu_rd_n_i | ~cpu_wr_n_i) & ~cpu_done & ~cpu_inflight.
  - The access is a write if cpu_wr_n_i is low, otherwise a read.
- cpu_done:
  - Set when the CPU access completes.
  - Cleared in any cycle where cpu_cs_i is low.
  - Result: exactly one RAM access per Z80 memory cycle.
- cpu_wait_n_o is combinational and equals ~(cpu_cs_i & (~rd_n | ~wr_n) & ~cpu_done).
- DMA pending: dma_req_i & ~dma_inflight.
- FSM states:
  - IDLE:
    - If one side is pending, grant it and go to ISSUE.
    - If both are pending, grant the side opposite last_grant. After reset, last_grant = DMA, so the CPU wins the first tie.
  - ISSUE (1 cycle):
    - ram_en_o = 1, ram_we_o = write, address and data from the owner.
    - For DMA, dma_ack_o = 1 this cycle.
    - For a write, mark done (CPU: cpu_done set) and go to IDLE.
    - For a read, go to DATA.
  - DATA (RAM_LAT cycles):
    - A 3-bit counter runs.
    - On the last cycle, capture ram_data_i into cpu_data_o (setting cpu_done) or into dma_data_o (with dma_valid_o pulsing next cycle).
    - Then go to IDLE.
- last_grant updates on every IDLE→ISSUE transition. Starvation is bounded to one access of the other side.
- Outside ISSUE: ram_en_o = 0, ram_we_o = 0; ram_addr_o and ram_data_o hold their last values.
- Reset values:
  - FSM = IDLE; last_grant = DMA; cpu_done = 0; counter = 0.
  - All outputs = 0, except cpu_wait_n_o, which follows its equation (1 while cpu_cs_i is low).
- Reset mid-access: the access is abandoned, with no ack and no valid. A CPU cycle still asserted after reset restarts as a new access.

## Timing
- Request seen in IDLE at cycle 0; ISSUE at cycle 1.
- Write:
  - cpu_done is visible at cycle 2, when cpu_wait_n_o goes high.
  - dma_ack_o pulses at cycle 1.
  - The next grant is possible at cycle 2.
- Read:
  - ram_data_i is sampled at the end of cycle 1+RAM_LAT.
  - cpu_data_o and cpu_done (or dma_data_o and dma_valid_o) are valid at cycle 2+RAM_LAT.
  - IDLE is entered at cycle 2+RAM_LAT.
- dma_req_i must remain high through the ack cycle. Deasserting before ack is a protocol violation and its outcome is unspecified.
- A CPU request arriving while a DMA access is in flight is held by WAIT; it is granted at the next IDLE.

## Structure
- A shared package `nanoz80_pkg` holds:
  - the state encoding (IDLE, ISSUE, DATA)
  - the owner constants OWN_CPU and OWN_DMA
  - the width of the RAM_LAT counter
- Single module, no sub-module: the FSM, arbiter flag and latency counter are small enough to stay inline.

## Test plan
- Reset with cpu_cs_i=0 → all outputs 0 and cpu_wait_n_o=1. Assert rst_i during DATA → no dma_valid_o, FSM IDLE.
- CPU read 0x1234 (RAM holds 0xA5), RAM_LAT=1 → ram_en_o at cycle 1, wait_n low for cycles 0–2, cpu_data_o=0xA5 at cycle 3. Holding cs for 10 more cycles → no second ram_en_o.
- DMA write 0x3C to 0x8000 → dma_ack_o and ram_we_o at cycle 1, address 0x8000, data 0x3C. The next DMA request is granted at cycle 2.
- CPU and DMA requesting in the same cycle after reset → CPU granted first, DMA second. Repeat the tie → grants alternate.
- CPU request during a DMA read with RAM_LAT=3 → wait_n stays low until the DMA completes; CPU ISSUE in the cycle after DMA IDLE re-entry. dma_valid_o pulses once.
- Back-to-back CPU cycles with cs dropping for 1 cycle between them → two distinct accesses; cpu_done clears on the cs-low cycle.

Source files
------------

// File: rtl/nanoz80_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nanoz80_pkg
// Description : Shared encodings for the nanoZ80 memory subsystem (RAM
//               arbiter state machine, access owner, latency counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package nanoz80_pkg;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int LAT_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Serialises Z80 and DMA accesses onto one RAM port, stretching
//               CPU cycles with WAIT_n and strobing DMA read data.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import nanoz80_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_cs_i,
    input  logic              cpu_rd_n_i,
    input  logic              cpu_wr_n_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_wait_n_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_data_i,
    output logic              dma_ack_o,
    output logic [DATA_W-1:0] dma_data_o,
    output logic              dma_valid_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam logic [LAT_CNT_W-1:0] c_lat_last = LAT_CNT_W'(RAM_LAT - 1);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_next;
    logic                 r_owner;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_last_grant;
    logic                 r_cpu_done;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]    r_cpu_data;
    logic [DATA_W-1:0]    r_dma_data;
    logic                 r_dma_valid;

    logic w_cpu_access;
    logic w_cpu_inflight;
    logic w_dma_inflight;
    logic w_cpu_pend;
    logic w_dma_pend;
    logic w_grant;
    logic w_grant_owner;
    logic w_data_last;

    assign w_cpu_access   = cpu_cs_i & (~cpu_rd_n_i | ~cpu_wr_n_i);
    assign w_cpu_inflight = (r_state != ST_IDLE) & (r_owner == OWN_CPU);
    assign w_dma_inflight = (r_state != ST_IDLE) & (r_owner == OWN_DMA);
    assign w_cpu_pend     = w_cpu_access & ~r_cpu_done & ~w_cpu_inflight;
    assign w_dma_pend     = dma_req_i & ~w_dma_inflight;
    assign w_grant        = (r_state == ST_IDLE) & (w_cpu_pend | w_dma_pend);
    assign w_data_last    = (r_state == ST_DATA) & (r_cnt == c_lat_last);

    // On a tie the side that did not win last time gets the port.
    assign w_grant_owner  = (w_cpu_pend & w_dma_pend) ? ~r_last_grant :
                            (w_dma_pend ? OWN_DMA : OWN_CPU);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = r_we ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_data_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_en_o  = 1'b0;
        ram_we_o  = 1'b0;
        dma_ack_o = 1'b0;
        if (r_state == ST_ISSUE) begin
            ram_en_o  = 1'b1;
            ram_we_o  = r_we;
            dma_ack_o = (r_owner == OWN_DMA);
        end
    end

    assign cpu_wait_n_o = ~(w_cpu_access & ~r_cpu_done);
    assign ram_addr_o   = r_addr;
    assign ram_data_o   = r_wdata;
    assign cpu_data_o   = r_cpu_data;
    assign dma_data_o   = r_dma_data;
    assign dma_valid_o  = r_dma_valid;

    // Owner request is captured at grant so the RAM bus holds it between accesses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner      <= OWN_CPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= OWN_DMA;
        end else if (w_grant) begin
            r_owner      <= w_grant_owner;
            r_last_grant <= w_grant_owner;
            if (w_grant_owner == OWN_DMA) begin
                r_we    <= dma_we_i;
                r_addr  <= dma_addr_i;
                r_wdata <= dma_data_i;
            end else begin
                r_we    <= ~cpu_wr_n_i;
                r_addr  <= cpu_addr_i;
                r_wdata <= cpu_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_DATA) begin
            r_cnt <= w_data_last ? '0 : r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // cpu_done blocks a second access until the Z80 drops its chip select.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpu_done <= 1'b0;
        end else if (!cpu_cs_i) begin
            r_cpu_done <= 1'b0;
        end else if (((r_state == ST_ISSUE) & r_we & (r_owner == OWN_CPU)) |
                     (w_data_last & (r_owner == OWN_CPU))) begin
            r_cpu_done <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpu_data  <= '0;
            r_dma_data  <= '0;
            r_dma_valid <= 1'b0;
        end else begin
            r_dma_valid <= w_data_last & (r_owner == OWN_DMA);
            if (w_data_last & (r_owner == OWN_CPU)) begin
                r_cpu_data <= ram_data_i;
            end
            if (w_data_last & (r_owner == OWN_DMA)) begin
                r_dma_data <= ram_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed scoreboard bench for ram_arbiter at RAM_LAT=1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } ram_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cs = 1'b0, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;

    logic [7:0]  cpu_data1, dma_data1, ram_wdata1, ram_rdata1;
    logic        cpu_wait_n1, dma_ack1, dma_valid1, ram_en1, ram_we1;
    logic [15:0] ram_addr1;
    logic [7:0]  cpu_data3, dma_data3, ram_wdata3, ram_rdata3;
    logic        cpu_wait_n3, dma_ack3, dma_valid3, ram_en3, ram_we3;
    logic [15:0] ram_addr3;

    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem3 [0:65535];
    logic [7:0]  p3_0, p3_1, p3_2;

    ram_t        ram_q[$];
    logic [7:0]  dma_q[$];
    logic [7:0]  cpu_q[$];
    ram_t        e_ram;
    logic [7:0]  e_dma;

    int checks = 0;
    int errors = 0;
    int nv;
    int en_cyc;
    int last_low;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .cpu_cs_i(cpu_cs), .cpu_rd_n_i(cpu_rd_n), .cpu_wr_n_i(cpu_wr_n),
        .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_data_o(cpu_data1), .cpu_wait_n_o(cpu_wait_n1),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_data_i(dma_wdata), .dma_ack_o(dma_ack1), .dma_data_o(dma_data1),
        .dma_valid_o(dma_valid1), .ram_en_o(ram_en1), .ram_we_o(ram_we1),
        .ram_addr_o(ram_addr1), .ram_data_o(ram_wdata1), .ram_data_i(ram_rdata1)
    );

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RAM_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .cpu_cs_i(cpu_cs), .cpu_rd_n_i(cpu_rd_n), .cpu_wr_n_i(cpu_wr_n),
        .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_data_o(cpu_data3), .cpu_wait_n_o(cpu_wait_n3),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_data_i(dma_wdata), .dma_ack_o(dma_ack3), .dma_data_o(dma_data3),
        .dma_valid_o(dma_valid3), .ram_en_o(ram_en3), .ram_we_o(ram_we3),
        .ram_addr_o(ram_addr3), .ram_data_o(ram_wdata3), .ram_data_i(ram_rdata3)
    );

    // RAM models: read data appears RAM_LAT cycles after enable, garbage otherwise.
    always @(posedge clk) begin
        if (ram_en1 && ram_we1) mem1[ram_addr1] <= ram_wdata1;
        ram_rdata1 <= (ram_en1 && !ram_we1) ? mem1[ram_addr1] : 8'hEE;
    end

    always @(posedge clk) begin
        if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_wdata3;
        p3_0 <= (ram_en3 && !ram_we3) ? mem3[ram_addr3] : 8'hEE;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign ram_rdata3 = p3_2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic exp_ram(input logic we, input logic [15:0] a, input logic [7:0] d);
        ram_t e;
        e.we   = we;
        e.addr = a;
        e.data = d;
        ram_q.push_back(e);
    endtask

    task automatic wait_cpu(input string tag);
        int n = 0;
        smp();
        while (cpu_wait_n1 !== 1'b1 && n < 40) begin
            step();
            smp();
            n++;
        end
        check({tag, "_wait_n"}, 32'(cpu_wait_n1), 32'd1);
    endtask

    // Scoreboard monitor for the RAM_LAT=1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_en1) begin
                if (ram_q.size() == 0) begin
                    check("ram_unexpected", 32'(ram_en1), 32'd0);
                end else begin
                    e_ram = ram_q.pop_front();
                    check("ram_we", 32'(ram_we1), 32'(e_ram.we));
                    check("ram_addr", 32'(ram_addr1), 32'(e_ram.addr));
                    if (e_ram.we) check("ram_wdata", 32'(ram_wdata1), 32'(e_ram.data));
                end
            end
            if (dma_valid1) begin
                if (dma_q.size() == 0) begin
                    check("dma_unexpected", 32'(dma_valid1), 32'd0);
                end else begin
                    e_dma = dma_q.pop_front();
                    check("dma_rdata", 32'(dma_data1), 32'(e_dma));
                end
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step(); step(); smp();
        check("rst_outs1", 32'({cpu_data1, dma_ack1, dma_data1, dma_valid1, ram_en1, ram_we1}), 32'd0);
        check("rst_bus1", 32'({ram_addr1, ram_wdata1}), 32'd0);
        check("rst_wait_n1", 32'(cpu_wait_n1), 32'd1);
        check("rst_outs3", 32'({cpu_data3, dma_ack3, dma_data3, dma_valid3, ram_en3, ram_we3}), 32'd0);
        check("rst_wait_n3", 32'(cpu_wait_n3), 32'd1);
        step(); rst = 1'b0;

        // DMA writes, back to back; also preloads both RAMs
        step(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8000; dma_wdata = 8'h3C;
        exp_ram(1'b1, 16'h8000, 8'h3C);
        smp(); check("dmaw_ack_c0", 32'(dma_ack1), 32'd0);
        step(); smp();
        check("dmaw_ack_c1", 32'(dma_ack1), 32'd1);
        check("dmaw_we_c1", 32'(ram_we1), 32'd1);
        step(); dma_addr = 16'h1234; dma_wdata = 8'hA5; exp_ram(1'b1, 16'h1234, 8'hA5);
        smp(); check("dmaw2_ack_c2", 32'(dma_ack1), 32'd0);
        step(); smp(); check("dmaw2_ack_c3", 32'(dma_ack1), 32'd1);
        step(); dma_addr = 16'h0042; dma_wdata = 8'h5A; exp_ram(1'b1, 16'h0042, 8'h5A);
        step();
        step(); dma_addr = 16'h0043; dma_wdata = 8'hC3; exp_ram(1'b1, 16'h0043, 8'hC3);
        step();
        step(); dma_req = 1'b0; dma_we = 1'b0;
        step();

        // CPU read with RAM_LAT=1
        step(); cpu_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h1234;
        exp_ram(1'b0, 16'h1234, 8'h00); cpu_q.push_back(8'hA5);
        smp(); check("cpurd_wait_c0", 32'(cpu_wait_n1), 32'd0);
               check("cpurd_en_c0", 32'(ram_en1), 32'd0);
        step(); smp(); check("cpurd_en_c1", 32'(ram_en1), 32'd1);
        step(); smp(); check("cpurd_wait_c2", 32'(cpu_wait_n1), 32'd0);
        step(); smp(); check("cpurd_wait_c3", 32'(cpu_wait_n1), 32'd1);
        check("cpurd_data_c3", 32'(cpu_data1), 32'(cpu_q.pop_front()));
        for (int k = 0; k < 10; k++) begin
            step(); smp();
        end
        check("cpurd_hold_wait", 32'(cpu_wait_n1), 32'd1);
        step(); cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        step();

        // Back-to-back CPU cycles separated by one cs-low cycle
        step(); cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 8'h77;
        exp_ram(1'b1, 16'h0100, 8'h77);
        smp(); check("b2b_wr_wait_c0", 32'(cpu_wait_n1), 32'd0);
        step(); step(); smp(); check("b2b_wr_done_c2", 32'(cpu_wait_n1), 32'd1);
        step(); cpu_cs = 1'b0; cpu_wr_n = 1'b1;
        step(); cpu_cs = 1'b1; cpu_rd_n = 1'b0;
        exp_ram(1'b0, 16'h0100, 8'h00); cpu_q.push_back(8'h77);
        smp(); check("b2b_done_cleared", 32'(cpu_wait_n1), 32'd0);
        wait_cpu("b2b_rd");
        check("b2b_rd_data", 32'(cpu_data1), 32'(cpu_q.pop_front()));
        step(); cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        step(); step();

        // Tie after reset: CPU first, then DMA
        step(); rst = 1'b1;
        step(); step(); rst = 1'b0;
        step();
        cpu_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h0042;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0043;
        exp_ram(1'b0, 16'h0042, 8'h00); exp_ram(1'b0, 16'h0043, 8'h00);
        cpu_q.push_back(8'h5A); dma_q.push_back(8'hC3);
        smp(); check("tie1_wait_c0", 32'(cpu_wait_n1), 32'd0);
        step(); smp(); check("tie1_cpu_first", 32'(ram_addr1), 32'h0042);
                       check("tie1_ack_c1", 32'(dma_ack1), 32'd0);
        step(); step(); smp(); check("tie1_cpu_done_c3", 32'(cpu_wait_n1), 32'd1);
        check("tie1_cpu_data", 32'(cpu_data1), 32'(cpu_q.pop_front()));
        step(); smp(); check("tie1_dma_second", 32'(dma_ack1), 32'd1);
        step(); dma_req = 1'b0; cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        step(); step();

        // Lone CPU write leaves last_grant = CPU
        cpu_cs = 1'b1; cpu_wr_n = 1'b0; cpu_addr = 16'h0200; cpu_wdata = 8'h11;
        exp_ram(1'b1, 16'h0200, 8'h11);
        wait_cpu("lone_wr");
        step(); cpu_cs = 1'b0; cpu_wr_n = 1'b1;
        step();

        // Second tie: DMA wins this time
        step();
        cpu_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h0042;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h1234;
        exp_ram(1'b0, 16'h1234, 8'h00); exp_ram(1'b0, 16'h0042, 8'h00);
        dma_q.push_back(8'hA5); cpu_q.push_back(8'h5A);
        smp(); check("tie2_wait_c0", 32'(cpu_wait_n1), 32'd0);
        step(); smp(); check("tie2_dma_first", 32'(dma_ack1), 32'd1);
                       check("tie2_addr_c1", 32'(ram_addr1), 32'h1234);
        step(); dma_req = 1'b0;
        wait_cpu("tie2_cpu");
        check("tie2_cpu_data", 32'(cpu_data1), 32'(cpu_q.pop_front()));
        step(); cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        step(); step();

        // CPU request during a RAM_LAT=3 DMA read
        step(); rst = 1'b1;
        step(); step(); rst = 1'b0;
        step();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0043;
        exp_ram(1'b0, 16'h0043, 8'h00); exp_ram(1'b0, 16'h0042, 8'h00);
        dma_q.push_back(8'hC3);
        step(); cpu_cs = 1'b1; cpu_rd_n = 1'b0; cpu_addr = 16'h0042;
        smp(); check("lat3_ack_c1", 32'(dma_ack3), 32'd1);
        nv = 0; en_cyc = -1; last_low = -1;
        for (int k = 2; k <= 12; k++) begin
            step();
            if (k == 2) dma_req = 1'b0;
            smp();
            if (dma_valid3) nv++;
            if (ram_en3 && en_cyc < 0) en_cyc = k;
            if (!cpu_wait_n3) last_low = k;
            if (k == 5) begin
                check("lat3_valid_c5", 32'(dma_valid3), 32'd1);
                check("lat3_dma_data", 32'(dma_data3), 32'h00C3);
            end
            if (k == 10) check("lat3_cpu_data", 32'(cpu_data3), 32'h005A);
        end
        check("lat3_valid_count", 32'(nv), 32'd1);
        check("lat3_cpu_issue_cyc", 32'(en_cyc), 32'd6);
        check("lat3_wait_last_low", 32'(last_low), 32'd9);
        check("lat3_cpu_addr", 32'(ram_addr3), 32'h0042);
        step(); cpu_cs = 1'b0; cpu_rd_n = 1'b1;
        step(); step();

        // Reset during DATA abandons the access
        step(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0043;
        exp_ram(1'b0, 16'h0043, 8'h00);
        step(); smp(); check("rstmid_ack_c1", 32'(dma_ack3), 32'd1);
        step(); rst = 1'b1; dma_req = 1'b0;
        nv = 0;
        step(); smp(); if (dma_valid3) nv++;
        step(); rst = 1'b0;
        smp(); if (dma_valid3) nv++;
        step(); dma_req = 1'b1; dma_addr = 16'h0042;
        exp_ram(1'b0, 16'h0042, 8'h00); dma_q.push_back(8'h5A);
        smp(); if (dma_valid3) nv++;
        step(); smp();
        check("rst_fsm_idle3", 32'(dma_ack3), 32'd1);
        check("rst_fsm_idle1", 32'(dma_ack1), 32'd1);
        step(); dma_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            smp();
            if (dma_valid3) nv++;
            step();
        end
        check("rst_valid_count3", 32'(nv), 32'd1);
        check("rst_dma_data3", 32'(dma_data3), 32'h005A);

        step(); step();
        check("ram_q_empty", 32'(ram_q.size()), 32'd0);
        check("dma_q_empty", 32'(dma_q.size()), 32'd0);
        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
